id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the five-stage MIPS pipeline. Sits directly downstream of the general-purpose register file.
- Captures the two register-file read values, immediate and control for the instruction in ID.
- Resolves RAW hazards: captures forwarded data where it is available, and tags operands that EX must bypass late.
- Detects load-use hazards, inserts one bubble and stalls IF/ID. Honors flush from branch resolution and hold from downstream.

Parameters:
- XLEN, 32, datapath width.
- AW, 5, register address width (32 registers; $0 hardwired to zero).
- CW, 16, width of the opaque ALU/memory control bundle passed through.

Ports:
- clk  in  1  clock
- Reset  in  1  reset; asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rs, id_rt  in  AW  source register numbers (also drive the register file read addresses)
- id_dst  in  AW  destination register
- id_reg_write  in  1  instruction writes a GPR
- id_mem_read  in  1  instruction is a load
- id_ctrl  in  CW  control bundle
- id_imm  in  XLEN  sign/zero-extended immediate
- gpr_data1, gpr_data2  in  XLEN  register file combinational read data
- exm_reg_write, exm_mem_read  in  1  EX/MEM instruction writes a GPR / is a load
- exm_dst  in  AW  EX/MEM destination
- exm_result  in  XLEN  EX/MEM ALU result
- wb_reg_write  in  1  MEM/WB write enable (same signal driving register file write enable)
- wb_dst  in  AW  MEM/WB destination
- wb_data  in  XLEN  MEM/WB write data
- flush  in  1  squash the instruction entering EX
- hold  in  1  downstream busy; freeze this stage
- stall_id  out  1  IF/ID must hold (combinational)
- ex_valid, ex_reg_write, ex_mem_read  out  1  registered
- ex_pc, ex_op_a, ex_op_b, ex_imm  out  XLEN  registered
- ex_dst  out  AW  registered
- ex_ctrl  out  CW  registered
- ex_fwd_a, ex_fwd_b  out  2  registered late-bypass select: 00 use ex_op, 01 use exm_result, 10 use wb_data
- stall_count  out  32  saturating count of load-use stall cycles

Behaviour:
- Reset: every registered output and stall_count is 0. Reset asserted mid-stall or mid-hold clears everything; the first edge after release captures normally.
- "Producer P matches source s" requires all of: P valid and writes a GPR; P destination != 0; P destination == s.
- Per source (rs → a, rt → b), priority is evaluated combinationally at capture:
  - 1. Source is 0: op = 0, fwd = 00.
  - 2. Matches the instruction in EX (own ex_* regs) and ex_mem_read=1: load-use hazard.
  - 3. Matches the instruction in EX and it is not a load: op = don't-care (capture gpr value), fwd = 01.
  - 4. Matches EX/MEM and exm_mem_read=1: fwd = 10 (load data arrives via WB next cycle).
  - 5. Matches EX/MEM, not a load: op = exm_result, fwd = 00.
  - 6. Matches MEM/WB: op = wb_data, fwd = 00. This covers the register file's same-edge write/read.
  - 7. Otherwise: op = gpr_data, fwd = 00.
- load_use = id_valid and (hazard on a or hazard on b).
- Each clock edge, priority is flush > hold > load_use > normal:
  - flush: bubble (ex_valid, ex_reg_write, ex_mem_read = 0, fwd = 00; other fields don't-care, implementation clears them).
  - hold: all ex_* registers keep their values.
  - load_use: bubble as above.
  - normal: capture all id_* fields and the resolved operands; ex_valid = id_valid.
- stall_id = hold or (load_use and not flush). It is combinational, with 1-cycle effect.
- A load-use stall lasts exactly one cycle: the load then moves to MEM and rule 4 applies.
- stall_count increments on every edge where load_use and not flush and not hold; it saturates at FFFF_FFFF.
- Latency: 1 cycle ID → EX. Throughput: 1 per cycle absent hazards.

Decomposition:
- Shared package pipe_pkg: fwd_sel_t enum (FWD_NONE=00, FWD_EXM=01, FWD_WB=10); XLEN/AW constants; bubble control constant.
- One sub-module, hazard_resolve: purely combinational, instantiated twice (once per source). It returns operand, fwd select and load-use hazard flag.

Test Plan:
- Reset mid-stream: Reset=1 asynchronously → all outputs 0 immediately, stall_count=0. After release, the next edge captures id_pc=0x00400000.
- Same-cycle WB bypass: wb_reg_write=1, wb_dst=8, wb_data=0x12345678, id_rs=8, gpr_data1=0 → ex_op_a=0x12345678, ex_fwd_a=00.
- ALU dependency: EX holds addu $9 (ex_reg_write=1, not load); ID uses rt=9 → ex_fwd_b=01, stall_id=0.
- Load-use: EX holds lw $10; ID rs=10 → stall_id=1 one cycle, bubble (ex_valid=0), stall_count=1. The next edge captures the instruction with ex_fwd_a=10.
- $0 protection: all producers target $0 with data 0xDEADBEEF; ID rs=rt=0 → ex_op_a=ex_op_b=0, no stall.
- Flush vs hold vs load_use all asserted together: flush wins → bubble, stall_id=1 (from hold), stall_count unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants.
// Holds the bypass select encoding, datapath widths and the bubble control value.
package pipe_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int CW   = 16;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_EXM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_t;

  localparam logic [CW-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_resolve.sv
// Per-source operand resolution for the ID/EX register.
// In: source reg, regfile data, EX/EXM/WB producers. Out: operand, bypass select, load-use flag.
module hazard_resolve
  import pipe_pkg::*;
#(
  parameter int XLEN = pipe_pkg::XLEN,
  parameter int AW   = pipe_pkg::AW
) (
  input  logic [AW-1:0]   src,
  input  logic [XLEN-1:0] gpr,
  input  logic            ex_valid,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic [AW-1:0]   ex_dst,
  input  logic            exm_reg_write,
  input  logic            exm_mem_read,
  input  logic [AW-1:0]   exm_dst,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_reg_write,
  input  logic [AW-1:0]   wb_dst,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] op,
  output fwd_sel_t        fwd,
  output logic            hazard
);

  logic is_zero;
  logic m_ex;
  logic m_exm;
  logic m_wb;
  logic s_ex;
  logic s_exm;
  logic s_wb;

  assign is_zero = (src == '0);
  assign m_ex  = ex_valid && ex_reg_write
              && ex_dst != '0 && ex_dst == src;
  assign m_exm = exm_reg_write
              && exm_dst != '0 && exm_dst == src;
  assign m_wb  = wb_reg_write
              && wb_dst != '0 && wb_dst == src;

  // One-hot by construction: nearest producer wins.
  assign s_ex  = !is_zero && m_ex;
  assign s_exm = !is_zero && !m_ex && m_exm;
  assign s_wb  = !is_zero && !m_ex && !m_exm && m_wb;

  always_comb begin
    op     = gpr;
    fwd    = FWD_NONE;
    hazard = 1'b0;
    unique case (1'b1)
      is_zero: op = '0;
      s_ex: begin
        hazard = ex_mem_read;
        fwd    = ex_mem_read ? FWD_NONE : FWD_EXM;
      end
      s_exm: begin
        // Load in MEM: its data shows up on the WB path next cycle.
        if (exm_mem_read) fwd = FWD_WB;
        else              op  = exm_result;
      end
      s_wb:    op = wb_data;
      default: op = gpr;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall.
// In: ID fields, regfile data, EXM/WB producers, flush/hold. Out: ex_* regs, stall_id, stall_count.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = pipe_pkg::XLEN,
  parameter int AW   = pipe_pkg::AW,
  parameter int CW   = pipe_pkg::CW
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic [AW-1:0]   id_dst,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic [CW-1:0]   id_ctrl,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] gpr_data1,
  input  logic [XLEN-1:0] gpr_data2,
  input  logic            exm_reg_write,
  input  logic            exm_mem_read,
  input  logic [AW-1:0]   exm_dst,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_reg_write,
  input  logic [AW-1:0]   wb_dst,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            hold,
  output logic            stall_id,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_op_a,
  output logic [XLEN-1:0] ex_op_b,
  output logic [XLEN-1:0] ex_imm,
  output logic [AW-1:0]   ex_dst,
  output logic [CW-1:0]   ex_ctrl,
  output logic [1:0]      ex_fwd_a,
  output logic [1:0]      ex_fwd_b,
  output logic [31:0]     stall_count
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  fwd_sel_t        fwd_a;
  fwd_sel_t        fwd_b;
  logic            haz_a;
  logic            haz_b;
  logic            load_use;

  hazard_resolve #(.XLEN(XLEN), .AW(AW)) u_res_a (
    .src          (id_rs),
    .gpr          (gpr_data1),
    .ex_valid     (ex_valid),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_dst       (ex_dst),
    .exm_reg_write(exm_reg_write),
    .exm_mem_read (exm_mem_read),
    .exm_dst      (exm_dst),
    .exm_result   (exm_result),
    .wb_reg_write (wb_reg_write),
    .wb_dst       (wb_dst),
    .wb_data      (wb_data),
    .op           (op_a),
    .fwd          (fwd_a),
    .hazard       (haz_a)
  );

  hazard_resolve #(.XLEN(XLEN), .AW(AW)) u_res_b (
    .src          (id_rt),
    .gpr          (gpr_data2),
    .ex_valid     (ex_valid),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_dst       (ex_dst),
    .exm_reg_write(exm_reg_write),
    .exm_mem_read (exm_mem_read),
    .exm_dst      (exm_dst),
    .exm_result   (exm_result),
    .wb_reg_write (wb_reg_write),
    .wb_dst       (wb_dst),
    .wb_data      (wb_data),
    .op           (op_b),
    .fwd          (fwd_b),
    .hazard       (haz_b)
  );

  assign load_use = id_valid && (haz_a || haz_b);
  assign stall_id = hold || (load_use && !flush);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_pc        <= '0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_imm       <= '0;
      ex_dst       <= '0;
      ex_ctrl      <= CTRL_BUBBLE;
      ex_fwd_a     <= FWD_NONE;
      ex_fwd_b     <= FWD_NONE;
    end else if (flush || (!hold && load_use)) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_pc        <= '0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_imm       <= '0;
      ex_dst       <= '0;
      ex_ctrl      <= CTRL_BUBBLE;
      ex_fwd_a     <= FWD_NONE;
      ex_fwd_b     <= FWD_NONE;
    end else if (!hold) begin
      ex_valid     <= id_valid;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_pc        <= id_pc;
      ex_op_a      <= op_a;
      ex_op_b      <= op_b;
      ex_imm       <= id_imm;
      ex_dst       <= id_dst;
      ex_ctrl      <= id_ctrl;
      ex_fwd_a     <= fwd_a;
      ex_fwd_b     <= fwd_b;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      stall_count <= '0;
    end else if (load_use && !flush && !hold
                 && stall_count != '1) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule
